// File: rtl/seg7_scan_decoder_if.sv
// Signal bundle between a multiplexed 7-segment display bus and the scan decoder.
//   seg_n       : segment bus, active-low, bit0=a .. bit6=g
//   an_n        : per-digit enables, active-low
//   values      : decoded nibbles, digit i at [4i+3:4i]
//   valid       : digit i holds a decoded legal hex value
//   upd         : one-cycle pulse on a legal commit
//   upd_idx     : digit index of the latest legal commit
//   err_invalid : one-cycle pulse on a stable illegal segment pattern
//   err_multi   : one-cycle pulse on entry into a multiple-enable condition
//   dp_n / dp   : decimal point input / per-digit decoded decimal point
//                 (present only when SEG7DEC_DP_EN is defined)
// master = display side / bench, slave = decoder.
interface seg7_scan_decoder_if #(
  parameter int NDIGITS = 8
) ();
  localparam int IDXW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  logic [6:0]           seg_n;
  logic [NDIGITS-1:0]   an_n;
  logic [4*NDIGITS-1:0] values;
  logic [NDIGITS-1:0]   valid;
  logic                 upd;
  logic [IDXW-1:0]      upd_idx;
  logic                 err_invalid;
  logic                 err_multi;
`ifdef SEG7DEC_DP_EN
  logic                 dp_n;
  logic [NDIGITS-1:0]   dp;

  modport master (
    output seg_n, an_n, dp_n,
    input  values, valid, upd, upd_idx, err_invalid, err_multi, dp
  );
  modport slave (
    input  seg_n, an_n, dp_n,
    output values, valid, upd, upd_idx, err_invalid, err_multi, dp
  );
`else
  modport master (
    output seg_n, an_n,
    input  values, valid, upd, upd_idx, err_invalid, err_multi
  );
  modport slave (
    input  seg_n, an_n,
    output values, valid, upd, upd_idx, err_invalid, err_multi
  );
`endif
endinterface

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: watches a multiplexed active-low 7-segment bus and
// recovers the hex nibble shown on each digit. A pattern must be seen for
// STABLE_CYCLES consecutive identical registered samples before it is
// committed; illegal patterns raise err_invalid, multiple enables raise
// err_multi.
// Ports:
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : seg7_scan_decoder_if.slave (seg_n/an_n in; values, valid, upd,
//         upd_idx, err_invalid, err_multi out; dp_n/dp with SEG7DEC_DP_EN)
// Optional feature macro: SEG7DEC_DP_EN (decimal point capture).
module seg7_scan_decoder #(
  parameter int NDIGITS       = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  seg7_scan_decoder_if.slave   bus
);
  localparam int IDXW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  // One registered sample word: {dp_n,} an_n, seg_n. The stability compare
  // is a plain equality of the whole word.
`ifdef SEG7DEC_DP_EN
  localparam int SW = NDIGITS + 8;
`else
  localparam int SW = NDIGITS + 7;
`endif

  typedef enum logic [1:0] {IDLE, TRACK, HELD, MULTI} state_t;

  logic [SW-1:0]        smp_in, smp_q, smp_p;
  logic [6:0]           seg_q;
  logic [NDIGITS-1:0]   an_q, zeros;
  logic                 cls_none, cls_one, cls_multi, same;
  logic [IDXW-1:0]      idx;

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 commit;

  logic [3:0]           nib;
  logic                 legal, blank;

  logic [4*NDIGITS-1:0] values_q, values_d;
  logic [NDIGITS-1:0]   valid_q, valid_d;
  logic                 upd_q, upd_d;
  logic [IDXW-1:0]      upd_idx_q, upd_idx_d;
  logic                 err_inv_q, err_inv_d;
  logic                 err_multi_q, err_multi_d;

`ifdef SEG7DEC_DP_EN
  logic                 dp_n_q;
  logic [NDIGITS-1:0]   dp_q, dp_d;
  assign smp_in = {bus.dp_n, bus.an_n, bus.seg_n};
  assign dp_n_q = smp_q[SW-1];
  assign bus.dp = dp_q;
`else
  assign smp_in = {bus.an_n, bus.seg_n};
`endif

  assign seg_q = smp_q[6:0];
  assign an_q  = smp_q[7 +: NDIGITS];
  assign same  = (smp_q == smp_p);

  // Input stage: current and previous registered samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_q <= '1;
      smp_p <= '1;
    end else begin
      smp_q <= smp_in;
      smp_p <= smp_q;
    end
  end

  // Sample classification; a single zero is detected with the x&(x-1) trick.
  always_comb begin
    zeros     = ~an_q;
    cls_none  = (zeros == '0);
    cls_one   = !cls_none && ((zeros & (zeros - NDIGITS'(1))) == '0);
    cls_multi = !cls_none && !cls_one;
    idx       = '0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (zeros[i]) idx = IDXW'(i);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The counter holds the length of the current identical
  // run; it stops at STABLE because TRACK hands over to HELD on reaching it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cls_one) begin
          state_d = TRACK;
          cnt_d   = 8'd1;
        end else if (cls_multi) begin
          state_d = MULTI;
        end
      end
      TRACK, HELD: begin
        if (same) begin
          if (state_q == TRACK) begin
            if (cnt_q + 8'd1 >= STABLE) begin
              cnt_d   = STABLE;
              commit  = 1'b1;
              state_d = HELD;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end else if (cls_one) begin
          state_d = TRACK;
          cnt_d   = 8'd1;
        end else if (cls_multi) begin
          state_d = MULTI;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      MULTI: begin
        if (cls_one) begin
          state_d = TRACK;
          cnt_d   = 8'd1;
        end else if (cls_none) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Segment pattern decode (g..a, active-low).
  always_comb begin
    nib   = 4'h0;
    legal = 1'b1;
    blank = 1'b0;
    unique case (seg_q)
      7'b1000000: nib = 4'h0;
      7'b1111001: nib = 4'h1;
      7'b0100100: nib = 4'h2;
      7'b0110000: nib = 4'h3;
      7'b0011001: nib = 4'h4;
      7'b0010010: nib = 4'h5;
      7'b0000010: nib = 4'h6;
      7'b1111000: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0010000: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b0000011: nib = 4'hB;
      7'b1000110: nib = 4'hC;
      7'b0100001: nib = 4'hD;
      7'b0000110: nib = 4'hE;
      7'b0001110: nib = 4'hF;
      7'b1111111: begin
        legal = 1'b0;
        blank = 1'b1;
      end
      default:    legal = 1'b0;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    values_d    = values_q;
    valid_d     = valid_q;
    upd_d       = 1'b0;
    upd_idx_d   = upd_idx_q;
    err_inv_d   = 1'b0;
    err_multi_d = (state_d == MULTI) && (state_q != MULTI);
`ifdef SEG7DEC_DP_EN
    dp_d        = dp_q;
`endif
    if (commit) begin
      if (legal) begin
        values_d[idx*4 +: 4] = nib;
        valid_d[idx]         = 1'b1;
        upd_d                = 1'b1;
        upd_idx_d            = idx;
`ifdef SEG7DEC_DP_EN
        dp_d[idx]            = ~dp_n_q;
`endif
      end else begin
        valid_d[idx] = 1'b0;
        err_inv_d    = !blank;
`ifdef SEG7DEC_DP_EN
        dp_d[idx]    = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      values_q    <= '0;
      valid_q     <= '0;
      upd_q       <= 1'b0;
      upd_idx_q   <= '0;
      err_inv_q   <= 1'b0;
      err_multi_q <= 1'b0;
`ifdef SEG7DEC_DP_EN
      dp_q        <= '0;
`endif
    end else begin
      values_q    <= values_d;
      valid_q     <= valid_d;
      upd_q       <= upd_d;
      upd_idx_q   <= upd_idx_d;
      err_inv_q   <= err_inv_d;
      err_multi_q <= err_multi_d;
`ifdef SEG7DEC_DP_EN
      dp_q        <= dp_d;
`endif
    end
  end

  assign bus.values      = values_q;
  assign bus.valid       = valid_q;
  assign bus.upd         = upd_q;
  assign bus.upd_idx     = upd_idx_q;
  assign bus.err_invalid = err_inv_q;
  assign bus.err_multi   = err_multi_q;

endmodule
